// File: rtl/bs_sched_pkg.sv
// Shared types for the Black-Scholes dispatch scheduler and its neighbours.
// Holds the default engine count shared by the engine container and the result writer.
// Carries no logic, only enum typedefs and constants.
package bs_sched_pkg;

    // Default engine count. The engine container and the memory writer use it as well.
    localparam int BSMODS_DEF = 4;

    // Round-level sequencing state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Per-engine occupancy state.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOADED = 2'd1,
        BUSY   = 2'd2
    } eng_state_e;

endpackage

// File: rtl/bs_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr_i wins. Output is a one-hot grant plus its index.
// Latency: purely combinational, 0 cycles.
// Backpressure: none. The caller gates req_i, and a zero request vector yields no grant.
// Ports: req_i   request vector
//        ptr_i   index of the highest-priority requester
//        gnt_o   one-hot grant
//        gnt_idx_o  index of the granted requester
//        gnt_vld_o  a grant was made
module bs_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        // Walk the requesters starting at the pointer and wrapping. The first hit wins.
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    assign gnt_vld_o = found;

endmodule

// File: rtl/bs_dispatch_scheduler.sv
// Sequences one pricing round: it hands each option packet to a free BS engine by round-robin,
// drives that engine's start handshake, counts completions and runs the round cycle counter (Clocks).
// Latency: packet accept to BS_START is 1 cycle, and the final BS_DONE to the round_done pulse is 1 cycle.
// Backpressure: pkt_ready_o stays low while no engine is eligible or the round quota is dispatched.
// Ports: clock_i/reset_i  clock and synchronous active-high reset
//        round_start_i/round_len_i  begin a round of round_len_i packets
//        pkt_valid_i/pkt_ready_o    packet handshake with the packet assembler
//        REG_READY_i, hasUnusedData_i, BS_READY_i, BS_IDLE_i, BS_DONE_i  engine status
//        regEn_o, BS_START_o      engine load strobe and ap_start
//        DONE_TRANSMITTING_i      host readback finished
//        Clocks_o, round_done_o, busy_o, err_sticky_o  round status
module bs_dispatch_scheduler
    import bs_sched_pkg::*;
#(
    parameter int BSMODS = BSMODS_DEF,
    parameter int CNT_W  = 16,
    parameter int CLK_W  = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              round_start_i,
    input  logic [CNT_W-1:0]  round_len_i,
    input  logic              pkt_valid_i,
    output logic              pkt_ready_o,
    input  logic [BSMODS-1:0] REG_READY_i,
    input  logic [BSMODS-1:0] hasUnusedData_i,
    input  logic [BSMODS-1:0] BS_READY_i,
    input  logic [BSMODS-1:0] BS_IDLE_i,
    input  logic [BSMODS-1:0] BS_DONE_i,
    input  logic              DONE_TRANSMITTING_i,
    output logic [BSMODS-1:0] regEn_o,
    output logic [BSMODS-1:0] BS_START_o,
    output logic [CLK_W-1:0]  Clocks_o,
    output logic              round_done_o,
    output logic              busy_o,
    output logic              err_sticky_o
);

    localparam int IW = (BSMODS > 1) ? $clog2(BSMODS) : 1;

    sched_state_e      state_q, state_d;
    eng_state_e        eng_q [BSMODS];
    eng_state_e        eng_d [BSMODS];
    logic [BSMODS-1:0] start_q, start_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  disp_q, disp_d;
    logic [CNT_W-1:0]  comp_q, comp_d;
    logic [CLK_W-1:0]  clk_q, clk_d;
    logic              rdone_q, rdone_d;
    logic              err_q, err_d;

    logic              dispatch_en;
    logic [BSMODS-1:0] req;
    logic [BSMODS-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic [CNT_W-1:0]  done_cnt;
    logic              spurious;

    // An engine is eligible only when it is FREE in our books and also reports itself loadable and idle.
    assign dispatch_en = (state_q == RUN) && (disp_q < len_q) && pkt_valid_i;

    always_comb begin
        req = '0;
        for (int k = 0; k < BSMODS; k++) begin
            req[k] = dispatch_en && (eng_q[k] == FREE) && REG_READY_i[k] && BS_IDLE_i[k];
        end
    end

    bs_rr_arbiter #(
        .N  (BSMODS),
        .IW (IW)
    ) u_rr_arbiter (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign pkt_ready_o = gnt_vld;
    assign regEn_o     = gnt;

    // Per-engine bookkeeping. A BS_DONE counts only from BUSY, or from LOADED in the same cycle
    // the engine takes its inputs. Any other BS_DONE is spurious.
    always_comb begin
        done_cnt = '0;
        spurious = 1'b0;
        start_d  = '0;
        for (int k = 0; k < BSMODS; k++) begin
            eng_d[k] = eng_q[k];
        end
        for (int k = 0; k < BSMODS; k++) begin
            unique case (eng_q[k])
                FREE: begin
                    if (BS_DONE_i[k]) begin
                        spurious = 1'b1;
                    end
                    if (gnt[k]) begin
                        eng_d[k]   = LOADED;
                        start_d[k] = 1'b1;
                    end
                end
                LOADED: begin
                    if (BS_READY_i[k]) begin
                        if (BS_DONE_i[k]) begin
                            eng_d[k] = FREE;
                            done_cnt = done_cnt + CNT_W'(1);
                        end else begin
                            eng_d[k] = BUSY;
                        end
                    end else begin
                        // Keep asserting start for as long as the input register holds the packet.
                        start_d[k] = hasUnusedData_i[k];
                        if (BS_DONE_i[k]) begin
                            spurious = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (BS_DONE_i[k]) begin
                        eng_d[k] = FREE;
                        done_cnt = done_cnt + CNT_W'(1);
                    end
                end
                default: eng_d[k] = FREE;
            endcase
        end
    end

    // Round FSM and counters. The exit test uses the next completion count, so round_done
    // rises one cycle after the final BS_DONE.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        disp_d  = disp_q;
        comp_d  = comp_q;
        clk_d   = clk_q;
        rdone_d = 1'b0;
        err_d   = err_q;
        ptr_d   = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == IW'(BSMODS - 1)) ? '0 : gnt_idx + IW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (round_start_i) begin
                    state_d = RUN;
                    len_d   = round_len_i;
                    disp_d  = '0;
                    comp_d  = '0;
                    clk_d   = '0;
                end
            end
            RUN: begin
                if (!(&clk_q)) begin
                    clk_d = clk_q + CLK_W'(1);
                end
                if (gnt_vld) begin
                    disp_d = disp_q + CNT_W'(1);
                end
                // Clamp at len_q so a stray count can never push the counter past the round size.
                if ((len_q - comp_q) <= done_cnt) begin
                    comp_d = len_q;
                end else begin
                    comp_d = comp_q + done_cnt;
                end
                if (spurious) begin
                    err_d = 1'b1;
                end
                if (comp_d == len_q) begin
                    state_d = DONE;
                    rdone_d = 1'b1;
                end
            end
            DONE: begin
                if (DONE_TRANSMITTING_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            for (int k = 0; k < BSMODS; k++) begin
                eng_q[k] <= FREE;
            end
            start_q <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            disp_q  <= '0;
            comp_q  <= '0;
            clk_q   <= '0;
            rdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            eng_q   <= eng_d;
            start_q <= start_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            disp_q  <= disp_d;
            comp_q  <= comp_d;
            clk_q   <= clk_d;
            rdone_q <= rdone_d;
            err_q   <= err_d;
        end
    end

    assign BS_START_o   = start_q;
    assign Clocks_o     = clk_q;
    assign round_done_o = rdone_q;
    assign busy_o       = (state_q != IDLE);
    assign err_sticky_o = err_q;

endmodule

// File: tb/tb_bs_dispatch_scheduler.sv
module tb_bs_dispatch_scheduler;

    localparam int N       = 4;
    localparam int CNT_W   = 16;
    localparam int CLK_W   = 6;
    localparam int CLK_MAX = (1 << CLK_W) - 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset, round_start, pkt_valid, DONE_TRANSMITTING;
    logic [CNT_W-1:0] round_len;
    logic [N-1:0]     REG_READY, hasUnusedData, BS_READY, BS_IDLE, BS_DONE;
    logic             pkt_ready, round_done, busy, err_sticky;
    logic [N-1:0]     regEn, BS_START;
    logic [CLK_W-1:0] Clocks;

    bs_dispatch_scheduler #(.BSMODS(N), .CNT_W(CNT_W), .CLK_W(CLK_W)) dut (
        .clock_i             (clock),
        .reset_i             (reset),
        .round_start_i       (round_start),
        .round_len_i         (round_len),
        .pkt_valid_i         (pkt_valid),
        .pkt_ready_o         (pkt_ready),
        .REG_READY_i         (REG_READY),
        .hasUnusedData_i     (hasUnusedData),
        .BS_READY_i          (BS_READY),
        .BS_IDLE_i           (BS_IDLE),
        .BS_DONE_i           (BS_DONE),
        .DONE_TRANSMITTING_i (DONE_TRANSMITTING),
        .regEn_o             (regEn),
        .BS_START_o          (BS_START),
        .Clocks_o            (Clocks),
        .round_done_o        (round_done),
        .busy_o              (busy),
        .err_sticky_o        (err_sticky)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model. Phase: 0 idle, 1 running, 2 finished. Engine: 0 free, 1 waiting for inputs to be taken, 2 computing.
    int           m_phase, m_len, m_disp, m_comp, m_clk, m_ptr;
    int           m_eng [N];
    logic [N-1:0] m_start;
    bit           m_rdone, m_err;

    // Engine environment.
    bit e_has [N];
    bit e_run [N];
    int e_rwait [N];
    int e_dwait [N];

    // Stimulus knobs.
    int           p_valid, p_regrdy, p_spur, max_rwait, max_dwait;
    logic [N-1:0] rr_mask;

    function automatic void model_reset();
        m_phase = 0; m_len = 0; m_disp = 0; m_comp = 0; m_clk = 0; m_ptr = 0;
        m_start = '0; m_rdone = 0; m_err = 0;
        for (int k = 0; k < N; k++) m_eng[k] = 0;
    endfunction

    function automatic int pick_engine();
        if (m_phase != 1 || m_disp >= m_len || !pkt_valid) return -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (m_eng[k] == 0 && REG_READY[k] && BS_IDLE[k]) return k;
        end
        return -1;
    endfunction

    task automatic drive_env();
        pkt_valid = ($urandom_range(99) < p_valid);
        for (int e = 0; e < N; e++) begin
            REG_READY[e]     = rr_mask[e] && ($urandom_range(99) < p_regrdy);
            hasUnusedData[e] = e_has[e];
            BS_IDLE[e]       = !(e_has[e] || e_run[e]);
            BS_READY[e]      = e_has[e] && m_start[e] && (e_rwait[e] == 0);
            BS_DONE[e]       = (BS_READY[e] && e_dwait[e] == 0) || (e_run[e] && e_dwait[e] == 0) ||
                               (!e_has[e] && !e_run[e] && ($urandom_range(99) < p_spur));
        end
    endtask

    task automatic env_step(input int g, input bit rst);
        for (int e = 0; e < N; e++) begin
            if (BS_READY[e]) begin
                e_has[e] = 0;
                if (!BS_DONE[e]) begin
                    e_run[e]   = 1;
                    e_dwait[e] = e_dwait[e] - 1;
                end
            end else if (e_has[e] && m_start[e] && e_rwait[e] > 0) begin
                e_rwait[e] = e_rwait[e] - 1;
            end else if (e_run[e]) begin
                if (BS_DONE[e]) e_run[e] = 0;
                else            e_dwait[e] = e_dwait[e] - 1;
            end
            if (g == e) begin
                e_has[e]   = 1;
                e_rwait[e] = $urandom_range(max_rwait);
                e_dwait[e] = $urandom_range(max_dwait);
            end
            if (rst) e_has[e] = 0;
        end
    endtask

    task automatic model_step(input int g);
        int           dones;
        bit           spur;
        int           ne [N];
        logic [N-1:0] ns;
        if (reset) begin
            model_reset();
            return;
        end
        dones = 0; spur = 0; ns = '0;
        for (int k = 0; k < N; k++) begin
            ne[k] = m_eng[k];
            if (BS_DONE[k]) begin
                if (m_eng[k] == 2 || (m_eng[k] == 1 && BS_READY[k])) dones++;
                else spur = 1;
            end
            if (k == g) begin
                ne[k] = 1; ns[k] = 1'b1;
            end else if (m_eng[k] == 1) begin
                if (BS_READY[k]) ne[k] = BS_DONE[k] ? 0 : 2;
                else             ns[k] = hasUnusedData[k];
            end else if (m_eng[k] == 2 && BS_DONE[k]) begin
                ne[k] = 0;
            end
        end
        m_rdone = 0;
        case (m_phase)
            0: if (round_start) begin
                m_phase = 1; m_len = int'(round_len); m_disp = 0; m_comp = 0; m_clk = 0;
            end
            1: begin
                m_clk = (m_clk == CLK_MAX) ? CLK_MAX : m_clk + 1;
                if (g >= 0) m_disp++;
                m_comp = (m_comp + dones > m_len) ? m_len : m_comp + dones;
                if (spur) m_err = 1;
                if (m_comp == m_len) begin
                    m_phase = 2; m_rdone = 1;
                end
            end
            default: if (DONE_TRANSMITTING) m_phase = 0;
        endcase
        if (g >= 0) m_ptr = (g + 1) % N;
        for (int k = 0; k < N; k++) m_eng[k] = ne[k];
        m_start = ns;
    endtask

    task automatic cycle(input bit rs, input bit rst, input bit dt);
        int           g;
        logic [N-1:0] exp_ren;
        @(posedge clock);
        #1;
        reset = rst; round_start = rs; DONE_TRANSMITTING = dt;
        drive_env();
        @(negedge clock);
        g = pick_engine();
        exp_ren = (g >= 0) ? (N'(1) << g) : '0;
        check_eq("pkt_ready", pkt_ready, g >= 0);
        check_eq("regEn", regEn, exp_ren);
        check_eq("BS_START", BS_START, m_start);
        check_eq("Clocks", Clocks, m_clk);
        check_eq("round_done", round_done, m_rdone);
        check_eq("busy", busy, m_phase != 0);
        check_eq("err_sticky", err_sticky, m_err);
        env_step(g, rst);
        model_step(g);
    endtask

    task automatic run_round(input int len, input int rst_at);
        int cyc;
        bit seen;
        round_len = CNT_W'(len);
        cycle(1, 0, 0);
        seen = 0; cyc = 0;
        while (!seen && cyc < 400) begin
            if (rst_at >= 0 && m_phase == 1 && m_disp == rst_at) begin
                cycle(0, 1, 0);
                return;
            end
            cycle($urandom_range(9) == 0, 0, 0);
            seen = round_done;
            cyc++;
        end
        check_eq("round_done_seen", seen, 1);
        if (!seen) begin
            cycle(0, 1, 0);
            return;
        end
        repeat ($urandom_range(3)) cycle($urandom_range(1), 0, 0);
        cycle(0, 0, 1);
    endtask

    initial begin
        reset = 1; round_start = 0; pkt_valid = 0; DONE_TRANSMITTING = 0; round_len = '0;
        REG_READY = '0; hasUnusedData = '0; BS_READY = '0; BS_IDLE = '0; BS_DONE = '0;
        for (int e = 0; e < N; e++) begin
            e_has[e] = 0; e_run[e] = 0; e_rwait[e] = 0; e_dwait[e] = 0;
        end
        p_valid = 100; p_regrdy = 100; p_spur = 0; max_rwait = 0; max_dwait = 3; rr_mask = '1;
        model_reset();
        repeat (3) @(posedge clock);

        // Reset state, then idle cycles with stray packets pending.
        repeat (3) cycle(0, 0, 0);

        // Everything ready: back-to-back grants 0,1,2,3.
        run_round(4, -1);
        // Engine 1 never loadable: grants skip it.
        rr_mask = 4'b1101; max_dwait = 6;
        run_round(6, -1);
        // Slow input acceptance keeps BS_START held.
        rr_mask = '1; max_rwait = 5;
        run_round(5, -1);
        // BS_READY and BS_DONE in the same cycle.
        max_rwait = 2; max_dwait = 0;
        run_round(4, -1);
        // Empty round.
        run_round(0, -1);
        // Spurious completions on free engines.
        max_dwait = 4; p_spur = 5;
        run_round(6, -1);
        p_spur = 0;
        // Reset after the third dispatch of eight, then a short clean round.
        max_dwait = 8;
        run_round(8, 3);
        run_round(2, -1);
        // Long round to push Clocks into saturation.
        p_valid = 50; max_rwait = 4; max_dwait = 20;
        run_round(16, -1);

        // Random soak.
        for (int r = 0; r < 30; r++) begin
            p_valid   = $urandom_range(30, 100);
            p_regrdy  = $urandom_range(30, 100);
            p_spur    = $urandom_range(3);
            max_rwait = $urandom_range(6);
            max_dwait = $urandom_range(10);
            rr_mask   = N'($urandom_range(1, 15));
            run_round($urandom_range(10), ($urandom_range(7) == 0) ? $urandom_range(3) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
